// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: port-select values, engine
// state encoding, status reset value and control-byte field positions.
package vdp_pkg;

    localparam logic PORT_DATA = 1'b0;  // 0xBE / 0x98
    localparam logic PORT_CTRL = 1'b1;  // 0xBF / 0x99

    localparam logic [7:0] STATUS_RESET = 8'h1F;
    localparam int unsigned REG_IDX_W = 3;

    // Second control byte: bit 7 selects a register write,
    // bit 6 selects write setup (vs. read setup) when bit 7 is clear.
    localparam int unsigned CMD_REG = 7;
    localparam int unsigned CMD_WR  = 6;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_REQ  = 2'd1,
        ENG_WAIT = 2'd2
    } eng_state_t;

endpackage

// File: rtl/vdp_status_flags.sv
// VDP status flags F (vblank), 5S (fifth sprite) and C (coincidence),
// the latched fifth-sprite number and the interrupt output.
//   clk, reset        : clock, async active-high reset
//   int_set/coll_set  : set pulses for F and C
//   fifth_set/num     : set pulse for 5S and the sprite number with it
//   clr               : clears F, 5S, C (set pulses on the same clk win)
//   irq_en            : R1[5]
//   status            : {F, 5S, C, fifth field}
//   irq_n             : active-low interrupt request
module vdp_status_flags
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       int_set,
    input  logic       coll_set,
    input  logic       fifth_set,
    input  logic [4:0] fifth_num,
    input  logic       clr,
    input  logic       irq_en,
    output logic [7:0] status,
    output logic       irq_n
);

    logic       f_q, s5_q, c_q;
    logic [4:0] fifth_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q     <= 1'b0;
            s5_q    <= 1'b0;
            c_q     <= 1'b0;
            fifth_q <= '0;
        end else begin
            if (int_set)       f_q  <= 1'b1;
            else if (clr)      f_q  <= 1'b0;
            if (coll_set)      c_q  <= 1'b1;
            else if (clr)      c_q  <= 1'b0;
            if (fifth_set)     s5_q <= 1'b1;
            else if (clr)      s5_q <= 1'b0;
            // Only the first fifth-sprite event since the last clear is kept.
            if (fifth_set && !s5_q) fifth_q <= fifth_num;
        end
    end

    always_comb begin
        status = {f_q, s5_q, c_q, (s5_q ? fifth_q : STATUS_RESET[4:0])};
        irq_n  = ~(f_q & irq_en);
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side sequencer for TMS9918-style VRAM and VDP registers.
//   clk, reset          : clock (cpuClock domain), async active-high reset
//   cpu_ce              : one-clk strobe per CPU clock edge
//   io_wr, io_rd        : CPU I/O write/read levels
//   port_sel            : 0 = data port, 1 = control/status port
//   cpu_din / cpu_dout  : CPU data in / read data out
//   vram_*              : single-byte request interface to the fetch arbiter
//   regs                : R0..R7 packed {R7,...,R0}
//   int_set, coll_set, fifth_set, fifth_num : status flag events
//   irq_n               : interrupt request, active low
//   overrun             : sticky, a data-port access was refused while busy
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned N_REGS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_ce,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic                  port_sel,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_gnt,
    input  logic                  vram_rvalid,
    input  logic [7:0]            vram_rdata,
    output logic [8*N_REGS-1:0]   regs,
    input  logic                  int_set,
    input  logic                  coll_set,
    input  logic                  fifth_set,
    input  logic [4:0]            fifth_num,
    output logic                  irq_n,
    output logic                  overrun
);

    eng_state_t state_q, state_d;

    logic [N_REGS-1:0][7:0] regs_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [ADDR_W-1:0]      setup_addr;
    logic [7:0]             first_q, buffer_q, status;
    logic                   flag_q, wr_prev_q, rd_prev_q, stat_pend_q;
    logic                   wr_stb, rd_stb, busy, stat_clr;
    logic                   ctrl_second, read_setup, start_op;

    // Edge detection is done in the cpu_ce domain so a held level acts once.
    always_comb begin
        wr_stb      = cpu_ce & io_wr & ~wr_prev_q;
        rd_stb      = cpu_ce & io_rd & ~rd_prev_q;
        busy        = (state_q != ENG_IDLE);
        stat_clr    = cpu_ce & ~io_rd & stat_pend_q;
        setup_addr  = ADDR_W'({cpu_din[5:0], first_q});
        ctrl_second = wr_stb & (port_sel == PORT_CTRL) & flag_q;
        read_setup  = ctrl_second & ~cpu_din[CMD_REG] & ~cpu_din[CMD_WR];
        start_op    = ~busy & (((wr_stb | rd_stb) & (port_sel == PORT_DATA)) | read_setup);
        vram_req    = (state_q == ENG_REQ);
        cpu_dout    = (port_sel == PORT_CTRL) ? status : buffer_q;
        regs        = regs_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ENG_IDLE: if (start_op)    state_d = ENG_REQ;
            ENG_REQ:  if (vram_gnt)    state_d = vram_we ? ENG_IDLE : ENG_WAIT;
            ENG_WAIT: if (vram_rvalid) state_d = ENG_IDLE;
            default:                   state_d = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ENG_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q      <= '0;
            addr_q      <= '0;
            first_q     <= '0;
            buffer_q    <= '0;
            flag_q      <= 1'b0;
            wr_prev_q   <= 1'b0;
            rd_prev_q   <= 1'b0;
            stat_pend_q <= 1'b0;
            overrun     <= 1'b0;
            vram_we     <= 1'b0;
            vram_addr   <= '0;
            vram_wdata  <= '0;
        end else begin
            if (cpu_ce) begin
                wr_prev_q <= io_wr;
                rd_prev_q <= io_rd;
            end
            if (stat_clr) stat_pend_q <= 1'b0;

            // Grant increment comes first so a same-clk address setup overrides it.
            if (state_q == ENG_REQ && vram_gnt) addr_q <= addr_q + ADDR_W'(1);
            if (state_q == ENG_WAIT && vram_rvalid) buffer_q <= vram_rdata;

            if (wr_stb) begin
                if (port_sel == PORT_CTRL) begin
                    if (!flag_q) begin
                        first_q <= cpu_din;
                        flag_q  <= 1'b1;
                    end else begin
                        flag_q <= 1'b0;
                        if (cpu_din[CMD_REG]) begin
                            regs_q[cpu_din[REG_IDX_W-1:0]] <= first_q;
                        end else begin
                            addr_q <= setup_addr;
                            if (!cpu_din[CMD_WR]) begin
                                if (busy) begin
                                    overrun <= 1'b1;
                                end else begin
                                    vram_we   <= 1'b0;
                                    vram_addr <= setup_addr;
                                end
                            end
                        end
                    end
                end else if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    flag_q     <= 1'b0;
                    vram_we    <= 1'b1;
                    vram_addr  <= addr_q;
                    vram_wdata <= cpu_din;
                    buffer_q   <= cpu_din;
                end
            end

            if (rd_stb) begin
                if (port_sel == PORT_CTRL) begin
                    flag_q      <= 1'b0;
                    stat_pend_q <= 1'b1;
                end else if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    flag_q    <= 1'b0;
                    vram_we   <= 1'b0;
                    vram_addr <= addr_q;
                end
            end
        end
    end

    vdp_status_flags u_status (
        .clk       (clk),
        .reset     (reset),
        .int_set   (int_set),
        .coll_set  (coll_set),
        .fifth_set (fifth_set),
        .fifth_num (fifth_num),
        .clr       (stat_clr),
        .irq_en    (regs_q[1][5]),
        .status    (status),
        .irq_n     (irq_n)
    );

endmodule

// File: tb/tb_vdp_cpu_port.sv
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_ce = 1'b1;
    logic        io_wr = 1'b0, io_rd = 1'b0, port_sel = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        vram_req, vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_gnt = 1'b0, vram_rvalid = 1'b0;
    logic [7:0]  vram_rdata = '0;
    logic [63:0] regs;
    logic        int_set = 1'b0, coll_set = 1'b0, fifth_set = 1'b0;
    logic [4:0]  fifth_num = '0;
    logic        irq_n, overrun;

    int n_checks = 0;
    int n_errors = 0;

    vdp_cpu_port #(.ADDR_W(14), .N_REGS(8)) dut (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .io_wr(io_wr), .io_rd(io_rd),
        .port_sel(port_sel), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_gnt(vram_gnt), .vram_rvalid(vram_rvalid),
        .vram_rdata(vram_rdata), .regs(regs), .int_set(int_set), .coll_set(coll_set),
        .fifth_set(fifth_set), .fifth_num(fifth_num), .irq_n(irq_n), .overrun(overrun)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic p, input logic [7:0] d);
        @(negedge clk);
        port_sel = p; cpu_din = d; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic p, output logic [7:0] d);
        @(negedge clk);
        port_sel = p; io_rd = 1'b1;
        #1 d = cpu_dout;
        @(negedge clk);
        io_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!vram_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_req_seen"}, vram_req, 1'b1);
    endtask

    task automatic grant(input string name, input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({name, "_req_held"}, vram_req, 1'b1);
        end
        @(negedge clk);
        vram_gnt = 1'b1;
        @(negedge clk);
        vram_gnt = 1'b0;
    endtask

    task automatic rdata_pulse(input logic [7:0] d);
        @(negedge clk);
        vram_rvalid = 1'b1; vram_rdata = d;
        @(negedge clk);
        vram_rvalid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [63:0] exp_regs;
    } reg_vec_t;

    reg_vec_t vecs[5];
    logic [7:0] rd;

    initial begin
        vecs[0] = '{8'h12, 8'h81, 64'h0000_0000_0000_1200};
        vecs[1] = '{8'hA5, 8'h87, 64'hA500_0000_0000_1200};
        vecs[2] = '{8'h3C, 8'h80, 64'hA500_0000_0000_123C};
        vecs[3] = '{8'hFF, 8'h89, 64'hA500_0000_0000_FF3C};
        vecs[4] = '{8'h20, 8'h81, 64'hA500_0000_0000_203C};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_regs", regs, 64'h0);
        chk("rst_req", vram_req, 1'b0);
        chk("rst_we", vram_we, 1'b0);
        chk("rst_addr", vram_addr, 14'h0);
        chk("rst_wdata", vram_wdata, 8'h0);
        chk("rst_dout_buf", cpu_dout, 8'h00);
        port_sel = 1'b1; #1;
        chk("rst_status", cpu_dout, 8'h1F);
        chk("rst_irq_n", irq_n, 1'b1);
        chk("rst_overrun", overrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Register writes from a table; address must stay untouched
        for (int i = 0; i < 5; i++) begin
            cpu_write(1'b1, vecs[i].b0);
            cpu_write(1'b1, vecs[i].b1);
            chk($sformatf("reg_vec%0d_regs", i), regs, vecs[i].exp_regs);
            chk($sformatf("reg_vec%0d_noreq", i), vram_req, 1'b0);
            chk($sformatf("reg_vec%0d_irq_n", i), irq_n, 1'b1);
        end
        // Held write level must not repeat (flag would toggle on a repeat)
        cpu_write(1'b0, 8'h01);
        wait_req("addr_unchanged");
        chk("addr_unchanged_addr", vram_addr, 14'h0000);
        grant("addr_unchanged", 0);

        // Write setup to 0x0000, two data writes with late grants
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h40);
        chk("wsetup_noreq", vram_req, 1'b0);
        cpu_write(1'b0, 8'hAA);
        wait_req("wr0");
        chk("wr0_we", vram_we, 1'b1);
        chk("wr0_addr", vram_addr, 14'h0000);
        chk("wr0_data", vram_wdata, 8'hAA);
        grant("wr0", 3);
        chk("wr0_released", vram_req, 1'b0);
        cpu_write(1'b0, 8'h55);
        wait_req("wr1");
        chk("wr1_addr", vram_addr, 14'h0001);
        chk("wr1_data", vram_wdata, 8'h55);
        grant("wr1", 3);
        chk("wr_overrun", overrun, 1'b0);

        // Data read: buffer holds last written byte; prefetch at 0x0002
        cpu_read(1'b0, rd);
        chk("rd_buf_after_wr", rd, 8'h55);
        wait_req("rd2");
        chk("rd2_we", vram_we, 1'b0);
        chk("rd2_addr", vram_addr, 14'h0002);
        grant("rd2", 0);
        // Data write while waiting for rvalid is dropped
        cpu_write(1'b0, 8'h77);
        chk("busy_overrun", overrun, 1'b1);
        rdata_pulse(8'hC3);
        cpu_write(1'b0, 8'h99);
        wait_req("after_drop");
        chk("after_drop_addr", vram_addr, 14'h0003);
        chk("after_drop_data", vram_wdata, 8'h99);
        grant("after_drop", 0);

        // Read setup at 0x3FFF, wrap to 0x0000
        cpu_write(1'b1, 8'hFF);
        cpu_write(1'b1, 8'h3F);
        wait_req("rsetup");
        chk("rsetup_addr", vram_addr, 14'h3FFF);
        chk("rsetup_we", vram_we, 1'b0);
        grant("rsetup", 1);
        rdata_pulse(8'h5A);
        cpu_read(1'b0, rd);
        chk("rsetup_buf", rd, 8'h5A);
        wait_req("wrap");
        chk("wrap_addr", vram_addr, 14'h0000);
        grant("wrap", 0);
        rdata_pulse(8'h11);

        // Status flags and interrupt
        @(negedge clk);
        port_sel = 1'b1;
        int_set = 1'b1;
        @(negedge clk);
        int_set = 1'b0;
        #1;
        chk("int_status", cpu_dout, 8'h9F);
        chk("int_irq_n", irq_n, 1'b0);
        cpu_read(1'b1, rd);
        chk("stat_read_val", rd, 8'h9F);
        #1;
        chk("stat_cleared", cpu_dout, 8'h1F);
        chk("stat_cleared_irq", irq_n, 1'b1);
        // Set on the clear clk wins
        cpu_write(1'b1, 8'h00);  // leaves flag=1; status read must clear it
        @(negedge clk);
        port_sel = 1'b1; io_rd = 1'b1;
        @(negedge clk);
        io_rd = 1'b0; int_set = 1'b1;
        @(negedge clk);
        int_set = 1'b0;
        #1;
        chk("set_wins_status", cpu_dout, 8'h9F);
        chk("set_wins_irq", irq_n, 1'b0);
        // Flag was cleared by the status read: this pair writes R3
        cpu_write(1'b1, 8'h6B);
        cpu_write(1'b1, 8'h83);
        chk("flag_clr_by_stat", regs[31:24], 8'h6B);
        cpu_read(1'b1, rd);
        #1;
        chk("stat_cleared2", cpu_dout, 8'h1F);
        // Fifth sprite latch keeps the first event
        @(negedge clk);
        fifth_set = 1'b1; fifth_num = 5'd3;
        @(negedge clk);
        fifth_num = 5'd7;
        @(negedge clk);
        fifth_set = 1'b0; coll_set = 1'b1;
        @(negedge clk);
        coll_set = 1'b0;
        #1;
        chk("fifth_coll_status", cpu_dout, 8'h63);
        chk("fifth_irq_n", irq_n, 1'b1);

        // Reset mid-operation
        cpu_write(1'b0, 8'h10);
        wait_req("pre_rst");
        cpu_write(1'b1, 8'h34);
        chk("pre_rst_req", vram_req, 1'b1);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_req", vram_req, 1'b0);
        chk("mid_rst_regs", regs, 64'h0);
        chk("mid_rst_overrun", overrun, 1'b0);
        chk("mid_rst_status", cpu_dout, 8'h1F);
        chk("mid_rst_irq", irq_n, 1'b1);
        chk("mid_rst_vaddr", vram_addr, 14'h0);
        chk("mid_rst_wdata", vram_wdata, 8'h0);
        @(negedge clk);
        reset = 1'b0;
        rdata_pulse(8'hEE);
        cpu_read(1'b0, rd);
        chk("late_rvalid_ignored", rd, 8'h00);
        cpu_write(1'b1, 8'h56);
        cpu_write(1'b1, 8'h82);
        chk("flag_reset_regs", regs, 64'h0000_0000_0056_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
